// File: rtl/air_quality_monitor.sv
// air_quality_monitor: hysteretic threshold controller driving purifier and
// humidifier enables, each filtered by a consecutive-sample confirmation counter.
// Optional feature macro: AQM_AVG_EN (4-sample running average of the input).
module air_quality_monitor #(
  parameter int unsigned HUMIDIFIER_num = 30,
  parameter int unsigned PURIFIER_num   = 100,
  parameter int unsigned HYST           = 5,
  parameter int unsigned CONFIRM        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] air_quality,
  output logic       purifier,
  output logic       humidifier
);

  localparam int unsigned DW = 8;  // input sample width
  localparam int unsigned VW = 9;  // threshold compare width (no wrap at 0/255)
  localparam int unsigned CW = 8;  // confirmation counter width
  localparam int unsigned SW = 10; // running-sum width

  localparam logic [VW-1:0] PUR_ON  = VW'(PURIFIER_num);
  localparam logic [VW-1:0] PUR_OFF = VW'(PURIFIER_num - HYST);
  localparam logic [VW-1:0] HUM_ON  = VW'(HUMIDIFIER_num);
  localparam logic [VW-1:0] HUM_OFF = VW'(HUMIDIFIER_num + HYST);
  localparam logic [VW-1:0] CONF    = VW'(CONFIRM);

  // Reject threshold sets whose turn-off points overlap, and out-of-range CONFIRM
  if (HUMIDIFIER_num + 2 * HYST > PURIFIER_num) begin : g_bad_thresholds
    $fatal(1, "air_quality_monitor: HUMIDIFIER_num + HYST must be <= PURIFIER_num - HYST");
  end
  if (CONFIRM < 1 || CONFIRM > 255) begin : g_bad_confirm
    $fatal(1, "air_quality_monitor: CONFIRM must be in 1..255");
  end

  logic          purifier_q,   purifier_d;
  logic          humidifier_q, humidifier_d;
  logic [CW-1:0] pur_cnt_q,    pur_cnt_d;
  logic [CW-1:0] hum_cnt_q,    hum_cnt_d;
  logic [VW-1:0] v;
  logic          pur_req;
  logic          hum_req;

`ifdef AQM_AVG_EN
  logic [2:0][DW-1:0] hist_q, hist_d;
  logic [SW-1:0]      sum;

  // Running average of the current sample and the three previous ones
  always_comb begin
    hist_d = {hist_q[1], hist_q[0], air_quality};
    sum    = SW'(air_quality) + SW'(hist_q[0]) + SW'(hist_q[1]) + SW'(hist_q[2]);
    v      = VW'(sum >> 2);
  end

  // Sample history; cleared on reset so the average ramps up afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  // Raw sample is the value under test
  always_comb begin
    v = {1'b0, air_quality};
  end
`endif

  // Hysteretic requests, confirmation counting and mutual exclusion
  always_comb begin
    purifier_d   = purifier_q;
    humidifier_d = humidifier_q;
    pur_cnt_d    = '0;
    hum_cnt_d    = '0;

    pur_req = purifier_q   ? (v <= PUR_OFF) : (v > PUR_ON);
    hum_req = humidifier_q ? (v >= HUM_OFF) : (v < HUM_ON);

    if (pur_req) begin
      if (VW'(pur_cnt_q) + VW'(1) >= CONF) begin
        purifier_d = ~purifier_q;
      end else begin
        pur_cnt_d = pur_cnt_q + CW'(1);
      end
    end

    if (hum_req) begin
      if (VW'(hum_cnt_q) + VW'(1) >= CONF) begin
        humidifier_d = ~humidifier_q;
      end else begin
        hum_cnt_d = hum_cnt_q + CW'(1);
      end
    end

    // Purifier wins a conflict; humidifier is held off and its count dropped
    if (purifier_d && humidifier_d) begin
      humidifier_d = 1'b0;
      hum_cnt_d    = '0;
    end
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      purifier_q   <= 1'b0;
      humidifier_q <= 1'b0;
      pur_cnt_q    <= '0;
      hum_cnt_q    <= '0;
    end else begin
      purifier_q   <= purifier_d;
      humidifier_q <= humidifier_d;
      pur_cnt_q    <= pur_cnt_d;
      hum_cnt_q    <= hum_cnt_d;
    end
  end

  assign purifier   = purifier_q;
  assign humidifier = humidifier_q;

endmodule

// File: tb/tb_air_quality_monitor.sv
// Directed bench for air_quality_monitor: default build (CONFIRM=1) plus a
// second instance built with CONFIRM=3.
module tb_air_quality_monitor;

  logic       clk;
  logic       rst;
  logic [7:0] aq;
  logic       purifier;
  logic       humidifier;
  logic       rst3;
  logic [7:0] aq3;
  logic       purifier3;
  logic       humidifier3;

  int errors = 0;
  int checks = 0;

  air_quality_monitor u_dut (
    .clk         (clk),
    .rst         (rst),
    .air_quality (aq),
    .purifier    (purifier),
    .humidifier  (humidifier)
  );

  air_quality_monitor #(.CONFIRM(3)) u_dut3 (
    .clk         (clk),
    .rst         (rst3),
    .air_quality (aq3),
    .purifier    (purifier3),
    .humidifier  (humidifier3)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one sample to the default instance, then check both outputs
  task automatic apply(input string tag, input logic [7:0] val,
                       input logic exp_p, input logic exp_h);
    aq = val;
    step();
    check({tag, ".purifier"},   purifier,   exp_p);
    check({tag, ".humidifier"}, humidifier, exp_h);
  endtask

  // Apply one sample to the CONFIRM=3 instance, then check the purifier
  task automatic apply3(input string tag, input logic [7:0] val, input logic exp_p);
    aq3 = val;
    step();
    check({tag, ".purifier"}, purifier3, exp_p);
  endtask

  initial begin
    rst  = 1'b1;
    aq   = 8'd0;
    rst3 = 1'b1;
    aq3  = 8'd0;
    #2;

    // Reset
    apply("reset", 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    apply("post_reset_50", 8'd50, 1'b0, 1'b0);

    // Low level
    apply("low_20", 8'd20, 1'b0, 1'b1);
    apply("low_back_50", 8'd50, 1'b0, 1'b0);

    // High level with hysteresis
    apply("high_120", 8'd120, 1'b1, 1'b0);
    apply("high_hold_98", 8'd98, 1'b1, 1'b0);
    apply("high_off_95", 8'd95, 1'b0, 1'b0);

    // Threshold edges
    apply("edge_100", 8'd100, 1'b0, 1'b0);
    apply("edge_101", 8'd101, 1'b1, 1'b0);
    apply("edge_30", 8'd30, 1'b0, 1'b0);
    apply("edge_29", 8'd29, 1'b0, 1'b1);
    apply("edge_hold_34", 8'd34, 1'b0, 1'b1);
    apply("edge_off_35", 8'd35, 1'b0, 1'b0);

    // Reset mid-operation
    apply("mid_200", 8'd200, 1'b1, 1'b0);
    rst = 1'b1;
    apply("mid_rst", 8'd200, 1'b0, 1'b0);
    rst = 1'b0;
    apply("mid_release", 8'd200, 1'b1, 1'b0);

    // Extremes with direct hand-over between outputs
    apply("ext_255", 8'd255, 1'b1, 1'b0);
    apply("ext_0", 8'd0, 1'b0, 1'b1);
    apply("ext_back_255", 8'd255, 1'b1, 1'b0);
    apply("ext_mid_60", 8'd60, 1'b0, 1'b0);

    // CONFIRM=3 instance
    apply3("c3_reset", 8'd0, 1'b0);
    check("c3_reset.humidifier", humidifier3, 1'b0);
    rst3 = 1'b0;
    apply3("c3_120_a", 8'd120, 1'b0);
    apply3("c3_120_b", 8'd120, 1'b0);
    apply3("c3_break_50", 8'd50, 1'b0);
    apply3("c3_120_1", 8'd120, 1'b0);
    apply3("c3_120_2", 8'd120, 1'b0);
    apply3("c3_120_3", 8'd120, 1'b1);
    apply3("c3_hold_50", 8'd50, 1'b1);
    check("c3_hold_50.humidifier", humidifier3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
